// File: rtl/anim_sprite.sv
// Multi-frame palettised sprite renderer: frame-indexed image ROM -> palette ROM, 4-cycle pixel latency.
// Optional transparency (palette index == TRANSPARENT_INDEX) is enabled by defining SPRITE_TRANSPARENCY_EN.

module sprite_rom #(
  parameter int unsigned RAM_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(RAM_DEPTH)-1:0] addr,
  input  logic                         load_en,
  input  logic [$clog2(RAM_DEPTH)-1:0] load_addr,
  input  logic [RAM_WIDTH-1:0]         load_data,
  output logic [RAM_WIDTH-1:0]         dout
);
  // Two-stage read (array register + reset-able output register); contents come from
  // image.mem / palette.mem in the implementation flow, the load port is tied off in use.
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    ram_data <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= ram_data;
  end
endmodule

module anim_sprite #(
  parameter int unsigned WIDTH             = 256,
  parameter int unsigned HEIGHT            = 256,
  parameter int unsigned NUM_FRAMES        = 4,
  parameter int unsigned FRAME_HOLD        = 6,
  parameter int unsigned FRAME_LINE        = 720,
  parameter int unsigned TRANSPARENT_INDEX = 0
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_in,
  input  logic [10:0]                   x_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    y_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          pop_in,
  output logic                          busy_out,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_out,
  output logic                          sprite_hit_out,
  output logic [7:0]                    red_out,
  output logic [7:0]                    green_out,
  output logic [7:0]                    blue_out
);
  localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
  localparam int unsigned IMG_DEPTH = FRAME_PIX * NUM_FRAMES;
  localparam int unsigned AW        = $clog2(IMG_DEPTH);
  localparam int unsigned FW        = $clog2(NUM_FRAMES);
  localparam int unsigned HW        = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  if (NUM_FRAMES < 2 || TRANSPARENT_INDEX > 255) begin : g_param_check
    $error("anim_sprite: NUM_FRAMES must be >= 2 and TRANSPARENT_INDEX must fit in 8 bits");
  end

  typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          boundary;

  assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'(FRAME_LINE));

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      frame_out <= '0;
      hold_cnt  <= '0;
      busy_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_in) begin
            state    <= ARMED;
            busy_out <= 1'b1;
          end
        end
        ARMED: begin
          if (boundary) begin
            frame_out <= FW'(1);
            hold_cnt  <= '0;
            state     <= PLAY;
          end
        end
        PLAY: begin
          if (boundary) begin
            if (hold_cnt == HW'(FRAME_HOLD - 1)) begin
              hold_cnt <= '0;
              if (frame_out == FW'(NUM_FRAMES - 1)) begin
                frame_out <= '0;
                state     <= IDLE;
                busy_out  <= 1'b0;
              end else begin
                frame_out <= frame_out + FW'(1);
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address arithmetic is modulo 2^AW, so out-of-sprite pixels may alias; they are masked later.
  logic [AW-1:0] img_addr;
  always_comb begin
    img_addr = AW'((32'(hcount_in) - 32'(x_in))
                   + (32'(vcount_in) - 32'(y_in)) * WIDTH
                   + 32'(frame_out) * FRAME_PIX);
  end

  logic [7:0]  img_index;
  logic [23:0] pal_data;

  sprite_rom #(.RAM_WIDTH(8), .RAM_DEPTH(IMG_DEPTH)) u_image_rom (
    .clk       (pixel_clk_in),
    .rst       (rst_in),
    .addr      (img_addr),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .dout      (img_index)
  );

  sprite_rom #(.RAM_WIDTH(24), .RAM_DEPTH(256)) u_palette_rom (
    .clk       (pixel_clk_in),
    .rst       (rst_in),
    .addr      (img_index),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .dout      (pal_data)
  );

  logic [10:0] hcount_pipe [4];
  logic [10:0] x_pipe      [4];
  logic [9:0]  vcount_pipe [4];
  logic [9:0]  y_pipe      [4];
  logic [3:0]  valid_pipe;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < 4; i++) begin
        hcount_pipe[i] <= '0;
        x_pipe[i]      <= '0;
        vcount_pipe[i] <= '0;
        y_pipe[i]      <= '0;
      end
      valid_pipe <= '0;
    end else begin
      hcount_pipe[0] <= hcount_in;
      x_pipe[0]      <= x_in;
      vcount_pipe[0] <= vcount_in;
      y_pipe[0]      <= y_in;
      for (int unsigned i = 1; i < 4; i++) begin
        hcount_pipe[i] <= hcount_pipe[i-1];
        x_pipe[i]      <= x_pipe[i-1];
        vcount_pipe[i] <= vcount_pipe[i-1];
        y_pipe[i]      <= y_pipe[i-1];
      end
      valid_pipe <= {valid_pipe[2:0], 1'b1};
    end
  end

  // Widened compares so x+WIDTH / y+HEIGHT cannot wrap past the screen edge.
  logic [11:0] h_w, x_w;
  logic [10:0] v_w, y_w;
  logic        in_sprite;
  logic        opaque;

  assign h_w = {1'b0, hcount_pipe[3]};
  assign x_w = {1'b0, x_pipe[3]};
  assign v_w = {1'b0, vcount_pipe[3]};
  assign y_w = {1'b0, y_pipe[3]};

  assign in_sprite = valid_pipe[3]
                   && (h_w >= x_w) && (h_w < x_w + 12'(WIDTH))
                   && (v_w >= y_w) && (v_w < y_w + 11'(HEIGHT));

`ifdef SPRITE_TRANSPARENCY_EN
  logic [7:0] index_pipe [2];

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      index_pipe[0] <= '0;
      index_pipe[1] <= '0;
    end else begin
      index_pipe[0] <= img_index;
      index_pipe[1] <= index_pipe[0];
    end
  end

  assign opaque = (index_pipe[1] != 8'(TRANSPARENT_INDEX));
`else
  assign opaque = 1'b1;
`endif

  assign sprite_hit_out = in_sprite && opaque;
  assign {red_out, green_out, blue_out} = sprite_hit_out ? pal_data : '0;
endmodule

// File: doc/anim_sprite.md
# anim_sprite

Parametrised, multi-frame successor to the single-image sprite renderer. It draws a WIDTH×HEIGHT palettised sprite at (x_in, y_in) from a frame-indexed image ROM and a palette ROM. A pop_in pulse plays an animation sequence through frames 1..NUM_FRAMES-1, then returns to frame 0. Frame changes are applied only during vertical blanking, so a frame never tears. It sits in the video pipeline between the timing generator and the pixel mixer.

## Interface
Parameters:
- WIDTH, 256: sprite width in pixels.
- HEIGHT, 256: sprite height in pixels.
- NUM_FRAMES, 4: frames stored back-to-back in the image ROM; must be ≥2.
- FRAME_HOLD, 6: video frames each animation frame is displayed.
- FRAME_LINE, 720: vcount value of the frame-boundary line (first blanking line).
- TRANSPARENT_INDEX, 0: palette index treated as transparent (only with SPRITE_TRANSPARENCY_EN).

Ports:
- pixel_clk_in, in, 1: pixel clock; the only clock.
- rst_in, in, 1: synchronous, active-high reset.
- x_in, in, 11: sprite left edge.
- hcount_in, in, 11: current pixel column.
- y_in, in, 10: sprite top edge.
- vcount_in, in, 10: current pixel row.
- pop_in, in, 1: single-cycle request to start the animation.
- busy_out, out, 1: high while the state machine is not IDLE.
- frame_out, out, $clog2(NUM_FRAMES): frame currently applied to addressing.
- sprite_hit_out, out, 1: high when the output pixel is an opaque sprite pixel.
- red_out, green_out, blue_out, out, 8 each: pixel colour; 0 when not hit.

## Operation
- Frame boundary: a cycle with hcount_in==0 and vcount_in==FRAME_LINE.
- State machine:
  - IDLE: frame=0. pop_in → ARMED.
  - ARMED: at the boundary, frame←1, hold_cnt←0, go to PLAY.
  - PLAY: on each boundary, hold_cnt increments. When hold_cnt==FRAME_HOLD-1, hold_cnt←0 and frame advances. If the frame was NUM_FRAMES-1, frame←0 and go to IDLE.
- pop_in in ARMED or PLAY is ignored (no restart).
- pop_in in the same cycle as a boundary while IDLE goes to ARMED only; playback starts at the next boundary.
- frame_out and hold_cnt change only on boundary cycles.
- ROM address:
  - (hcount_in−x_in) + (vcount_in−y_in)·WIDTH + frame·WIDTH·HEIGHT.
  - Width $clog2(WIDTH·HEIGHT·NUM_FRAMES); the result is truncated to this width.
  - Computed combinationally from the current inputs.
- Image ROM: RAM_WIDTH 8, depth WIDTH·HEIGHT·NUM_FRAMES, HIGH_PERFORMANCE (2-cycle), initialised from image.mem.
- Palette ROM: RAM_WIDTH 24, depth 256, HIGH_PERFORMANCE, initialised from palette.mem. It is addressed by the image ROM output; data is {R,G,B}.
- In-sprite test:
  - Uses hcount, vcount, x and y delayed 4 cycles.
  - Compares in 12/11-bit widened arithmetic so x+WIDTH and y+HEIGHT never wrap.
  - Condition: hcount∈[x, x+WIDTH) and vcount∈[y, y+HEIGHT).
- Palette index delay: the image ROM index is delayed 2 cycles to align with palette data for the transparency check.
- sprite_hit_out = in_sprite (and not transparent, with SPRITE_TRANSPARENCY_EN). RGB outputs are palette data when hit, else 0.
- Reset: state IDLE, frame_out=0, busy_out=0, hold_cnt=0, all delay registers 0.
  - Both ROMs' output registers are reset via rsta, so sprite_hit_out=0 and RGB=0 from the first cycle after reset.
  - Reset mid-animation aborts to frame 0 immediately.

## Timing
- Pixel latency: exactly 4 cycles from hcount/vcount/x/y to red/green/blue/sprite_hit_out.
- Throughput: one pixel per cycle; no stalls.
- busy_out rises the cycle after pop_in is sampled in IDLE. It falls the cycle after the final boundary that returns frame to 0.
- A full animation lasts (NUM_FRAMES−1)·FRAME_HOLD boundaries after arming.
- frame_out updates the cycle after the boundary cycle. Addresses use the new frame from that cycle; every visible pixel of a video frame uses one frame index.

## Configuration
- SPRITE_TRANSPARENCY_EN defined:
  - Pixels whose palette index equals TRANSPARENT_INDEX give sprite_hit_out=0 and RGB=0.
  - The index delay registers are instantiated.
- Undefined: every in-sprite pixel is opaque and the index delay registers are omitted.

## Test plan
- Static draw: x=100, y=50, frame 0, drive pixel (100,50) → 4 cycles later sprite_hit_out=1 and RGB = palette[image[0]]. Pixel (99,50) → hit=0, RGB=0.
- Edge wrap: x=1900, WIDTH=256 → pixels at hcount 1900..2047 hit; no false hit at hcount 0..107.
- Animation: NUM_FRAMES=4, FRAME_HOLD=2, pop_in → frame_out sequence 0,1,1,2,2,3,3,0 across successive boundaries. busy_out is high from pop_in+1 until the return to 0.
- Frame addressing: during frame 2, pixel (x,y) → address 2·WIDTH·HEIGHT; RGB matches palette[image[2·65536]].
- Ignored pop / reset: pop_in during PLAY leaves the sequence unchanged. rst_in asserted in frame 2 → frame_out=0, busy_out=0 the next cycle.
- Transparency (macro defined): image index 0 at (x,y) → sprite_hit_out=0, RGB=0. Index 5 → hit=1. With the macro undefined, index 0 → hit=1, RGB=palette[0].
